// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producers, the arbiter and the FIFO write port.
// Member names carry the arbiter's view (_i into the arbiter, _o out of it).
interface fifo_wr_arbiter_if #(
  parameter int unsigned width_p   = 8,
  parameter int unsigned num_req_p = 2
);
  logic [num_req_p*width_p-1:0] req_data_i;
  logic [num_req_p-1:0]         req_valid_i;
  logic [num_req_p-1:0]         req_last_i;
  logic [num_req_p-1:0]         req_ready_o;
  logic [width_p-1:0]           data_o;
  logic                         valid_o;
  logic                         ready_i;
  logic [num_req_p-1:0]         grant_o;
  logic                         busy_o;
  logic                         abort_o;

  modport master (
    input  req_data_i, req_valid_i, req_last_i, ready_i,
    output req_ready_o, data_o, valid_o, grant_o, busy_o, abort_o
  );

  modport slave (
    output req_data_i, req_valid_i, req_last_i, ready_i,
    input  req_ready_o, data_o, valid_o, grant_o, busy_o, abort_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one FIFO write port among num_req_p producers.
// Optional stall timeout is built only when FIFO_WR_ARB_TIMEOUT_EN is defined.
module fifo_wr_arbiter #(
  parameter int unsigned width_p   = 8,
  parameter int unsigned num_req_p = 2,
  parameter int unsigned timeout_p = 255
) (
  input  logic               clk_i,
  input  logic               reset_i,
  fifo_wr_arbiter_if.master  bus
);

  localparam int unsigned idx_w_lp = $clog2(num_req_p);

  typedef enum logic {
    IDLE,
    LOCK
  } state_e;

  state_e                state_q, state_d;
  logic [idx_w_lp-1:0]   owner_q, owner_d;
  logic [idx_w_lp-1:0]   last_owner_q, last_owner_d;
  logic [num_req_p-1:0]  grant_q, grant_d;
  logic                  busy_q, busy_d;

  logic [idx_w_lp-1:0]   pick;
  logic                  pick_found;
  int unsigned           cand;
  logic                  own_valid;
  logic                  own_last;
  logic                  xfer;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
  localparam int unsigned cnt_w_lp = $clog2(timeout_p + 1);
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
  logic                  abort_q, abort_d;
`endif

  // Owner mux: no register in the data path, only the owner sees ready.
  always_comb begin
    own_valid       = 1'b0;
    own_last        = 1'b0;
    bus.data_o      = '0;
    bus.req_ready_o = '0;
    for (int unsigned r = 0; r < num_req_p; r++) begin
      if (state_q == LOCK && owner_q == idx_w_lp'(r)) begin
        own_valid          = bus.req_valid_i[r];
        own_last           = bus.req_last_i[r];
        bus.data_o         = bus.req_data_i[r*width_p +: width_p];
        bus.req_ready_o[r] = bus.ready_i;
      end
    end
  end

  assign bus.valid_o = own_valid;
  assign xfer        = own_valid & bus.ready_i;

  // Round-robin scan starting just after the previous owner.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = 0;
    for (int unsigned i = 1; i <= num_req_p; i++) begin
      cand = (32'(last_owner_q) + i) % num_req_p;
      if (!pick_found && bus.req_valid_i[idx_w_lp'(cand)]) begin
        pick_found = 1'b1;
        pick       = idx_w_lp'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    abort_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d       = LOCK;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          busy_d        = 1'b1;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end
      LOCK: begin
        if (xfer && own_last) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          grant_d      = '0;
          busy_d       = 1'b0;
        end
`ifdef FIFO_WR_ARB_TIMEOUT_EN
        // Only owner-idle cycles count; FIFO-full stalls keep valid high and clear it.
        else if (!own_valid) begin
          if (cnt_q == cnt_w_lp'(timeout_p - 1)) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            grant_d      = '0;
            busy_d       = 1'b0;
            abort_d      = 1'b1;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= idx_w_lp'(num_req_p - 1);
      grant_q      <= '0;
      busy_q       <= 1'b0;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      abort_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
`endif
    end
  end

  assign bus.grant_o = grant_q;
  assign bus.busy_o  = busy_q;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
  assign bus.abort_o = abort_q;
`else
  assign bus.abort_o = 1'b0;
`endif

endmodule
